dcache_ctrl: RTL and testbench

//  Miss-handling controller between the CPU load/store port and the 4-line direct-mapped cache array.

---
 rtl/dcache_ctrl_pkg.sv | 33 +++
 rtl/dcache_ctrl_if.sv | 56 +++++
 rtl/dcache_ctrl_sat_counter.sv | 25 ++
 rtl/dcache_ctrl.sv | 135 +++++++++++++
 tb/tb_dcache_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared widths, address field layout and FSM states for the data-cache miss controller.
package dcache_ctrl_pkg;

   localparam int unsigned TAG_W   = 26;
   localparam int unsigned INDEX_W = 2;
   localparam int unsigned LINE_W  = 128;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_REFILL,
      ST_FILL
   } state_e;

   // Field order matches addr[31:6] tag, [5:4] index, [3:2] word, [1:0] byte.
   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [INDEX_W-1:0] index;
      logic [1:0]         word;
      logic [1:0]         byte_sel;
   } addr_t;

   function automatic addr_t split_addr(input logic [31:0] a);
      return addr_t'(a);
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [INDEX_W-1:0] index);
      return {tag, index, 4'b0000};
   endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU port, cache-array port and memory bus of the miss controller, bundled in one interface.
interface dcache_ctrl_if;
   import dcache_ctrl_pkg::*;

   logic                req_valid;
   logic                req_write;
   logic                req_byte;
   logic [31:0]         req_addr;
   logic [31:0]         req_wdata;
   logic [31:0]         rdata;
   logic                stall;

   logic                cache_write_word;
   logic                cache_write_block;
   logic                cache_byte_access;
   logic [INDEX_W-1:0]  cache_index;
   logic [1:0]          cache_word;
   logic [1:0]          cache_byte;
   logic [TAG_W-1:0]    cache_tag;
   logic [31:0]         cache_word_in;
   logic [LINE_W-1:0]   cache_block_in;
   logic                cache_hit;
   logic                cache_valid;
   logic                cache_dirty;
   logic [31:0]         cache_word_out;
   logic [LINE_W-1:0]   cache_block_out;
   logic [TAG_W-1:0]    cache_tag_out;

   logic                mem_req;
   logic                mem_we;
   logic [31:0]         mem_addr;
   logic [LINE_W-1:0]   mem_wdata;
   logic [LINE_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport master (
      input  req_valid, req_write, req_byte, req_addr, req_wdata,
      output rdata, stall,
      output cache_write_word, cache_write_block, cache_byte_access, cache_index,
      output cache_word, cache_byte, cache_tag, cache_word_in, cache_block_in,
      input  cache_hit, cache_valid, cache_dirty, cache_word_out, cache_block_out, cache_tag_out,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output req_valid, req_write, req_byte, req_addr, req_wdata,
      input  rdata, stall,
      input  cache_write_word, cache_write_block, cache_byte_access, cache_index,
      input  cache_word, cache_byte, cache_tag, cache_word_in, cache_block_in,
      output cache_hit, cache_valid, cache_dirty, cache_word_out, cache_block_out, cache_tag_out,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/dcache_ctrl_sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Miss handler for a 4-line direct-mapped cache: zero-latency hits, dirty-victim
// writeback and line refill over a 128-bit req/ack memory bus.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   dcache_ctrl_if.master    bus,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   state_e            state_q, state_d;
   addr_t             miss_addr_q, miss_addr_d;
   logic [31:0]       victim_addr_q, victim_addr_d;
   logic [LINE_W-1:0] victim_line_q, victim_line_d;
   logic [LINE_W-1:0] fill_line_q, fill_line_d;

   addr_t       req_fields, cur_addr;
   logic        stall, mem_req, mem_we, wr_word, wr_block, miss_inc, wb_inc;
   logic [31:0] mem_addr;

   assign req_fields = split_addr(bus.req_addr);

   always_comb begin
      state_d       = state_q;
      miss_addr_d   = miss_addr_q;
      victim_addr_d = victim_addr_q;
      victim_line_d = victim_line_q;
      fill_line_d   = fill_line_q;
      cur_addr      = miss_addr_q;
      stall         = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      wr_word       = 1'b0;
      wr_block      = 1'b0;
      miss_inc      = 1'b0;
      wb_inc        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cur_addr = req_fields;
            if (bus.req_valid) begin
               if (bus.cache_hit) begin
                  wr_word = bus.req_write;
               end else begin
                  stall       = 1'b1;
                  miss_inc    = 1'b1;
                  miss_addr_d = req_fields;
                  // Victim must be captured now: the array outputs move once the state leaves IDLE.
                  if (bus.cache_valid && bus.cache_dirty) begin
                     victim_addr_d = line_addr(bus.cache_tag_out, req_fields.index);
                     victim_line_d = bus.cache_block_out;
                     state_d       = ST_WRITEBACK;
                  end else begin
                     state_d = ST_REFILL;
                  end
               end
            end
         end
         ST_WRITEBACK: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = victim_addr_q;
            if (bus.mem_ack) begin
               wb_inc  = 1'b1;
               state_d = ST_REFILL;
            end
         end
         ST_REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = line_addr(miss_addr_q.tag, miss_addr_q.index);
            if (bus.mem_ack) begin
               fill_line_d = bus.mem_rdata;
               state_d     = ST_FILL;
            end
         end
         ST_FILL: begin
            stall    = 1'b1;
            wr_block = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         miss_addr_q   <= '0;
         victim_addr_q <= '0;
         victim_line_q <= '0;
         fill_line_q   <= '0;
      end else begin
         state_q       <= state_d;
         miss_addr_q   <= miss_addr_d;
         victim_addr_q <= victim_addr_d;
         victim_line_q <= victim_line_d;
         fill_line_q   <= fill_line_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (miss_inc),
      .count (miss_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wb_inc),
      .count (wb_count)
   );

   assign bus.rdata             = bus.cache_word_out;
   assign bus.stall             = stall;
   assign bus.cache_write_word  = wr_word;
   assign bus.cache_write_block = wr_block;
   assign bus.cache_byte_access = bus.req_byte;
   assign bus.cache_index       = cur_addr.index;
   assign bus.cache_word        = cur_addr.word;
   assign bus.cache_byte        = cur_addr.byte_sel;
   assign bus.cache_tag         = cur_addr.tag;
   assign bus.cache_word_in     = bus.req_wdata;
   assign bus.cache_block_in    = fill_line_q;
   assign bus.mem_req           = mem_req;
   assign bus.mem_we            = mem_we;
   assign bus.mem_addr          = mem_addr;
   assign bus.mem_wdata         = victim_line_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 4-line cache array and a
// fixed-latency line memory; expected values are hand-computed constants.
module tb_dcache_ctrl;
   import dcache_ctrl_pkg::*;

   localparam int unsigned MEM_LAT = 3;
   localparam int          BUDGET  = 40;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [CNT_W-1:0] miss_count, wb_count;
   int               n_vec = 0;
   int               n_err = 0;

   dcache_ctrl_if bus();

   dcache_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .miss_count (miss_count),
      .wb_count   (wb_count)
   );

   always #5 clock = ~clock;

   // Behavioural cache array: combinational lookup, writes on posedge.
   logic              arr_valid [4] = '{default: 1'b0};
   logic              arr_dirty [4] = '{default: 1'b0};
   logic [TAG_W-1:0]  arr_tag   [4] = '{default: '0};
   logic [LINE_W-1:0] arr_data  [4] = '{default: '0};
   logic [31:0]       arr_w;
   int                n_ww   = 0;
   int                n_fill = 0;

   always_comb begin
      arr_w               = arr_data[bus.cache_index][{bus.cache_word, 5'b0} +: 32];
      bus.cache_hit       = arr_valid[bus.cache_index] && (arr_tag[bus.cache_index] == bus.cache_tag);
      bus.cache_valid     = arr_valid[bus.cache_index];
      bus.cache_dirty     = arr_dirty[bus.cache_index];
      bus.cache_tag_out   = arr_tag[bus.cache_index];
      bus.cache_block_out = arr_data[bus.cache_index];
      bus.cache_word_out  = bus.cache_byte_access ? {24'h0, arr_w[{bus.cache_byte, 3'b0} +: 8]} : arr_w;
   end

   always @(posedge clock) begin
      if (bus.cache_write_block) begin
         arr_data[bus.cache_index]  <= bus.cache_block_in;
         arr_valid[bus.cache_index] <= 1'b1;
         arr_tag[bus.cache_index]   <= bus.cache_tag;
         arr_dirty[bus.cache_index] <= 1'b0;
         n_fill <= n_fill + 1;
      end else if (bus.cache_write_word) begin
         if (bus.cache_byte_access)
            arr_data[bus.cache_index][{bus.cache_word, bus.cache_byte, 3'b0} +: 8] <= bus.cache_word_in[7:0];
         else
            arr_data[bus.cache_index][{bus.cache_word, 5'b0} +: 32] <= bus.cache_word_in;
         arr_dirty[bus.cache_index] <= 1'b1;
         n_ww <= n_ww + 1;
      end
   end

   logic [LINE_W-1:0] mem_model [1024];
   logic [31:0]       txn_addr  [$];
   logic              txn_we    [$];
   logic [LINE_W-1:0] txn_wdata [$];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents a request and services the memory bus until stall drops (the hit cycle).
   task automatic access(input logic [31:0] a, input logic w, input logic b, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rd, output logic wr_seen);
      int req_cycles;
      req_cycles    = 0;
      stalls        = 0;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_byte  = b;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      #1;
      while (bus.stall && stalls < BUDGET) begin
         if (bus.mem_req) begin
            req_cycles++;
            if (req_cycles == MEM_LAT) begin
               txn_addr.push_back(bus.mem_addr);
               txn_we.push_back(bus.mem_we);
               txn_wdata.push_back(bus.mem_wdata);
               if (bus.mem_we) mem_model[bus.mem_addr[13:4]] = bus.mem_wdata;
               else            bus.mem_rdata = mem_model[bus.mem_addr[13:4]];
               bus.mem_ack = 1'b1;
               req_cycles  = 0;
            end
         end
         tick();
         bus.mem_ack = 1'b0;
         #1;
         stalls++;
      end
      if (bus.stall) check_eq("stall_timeout", 1'b1, 1'b0);
      rd      = bus.rdata;
      wr_seen = bus.cache_write_word;
   endtask

   task automatic finish_access();
      tick();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_byte  = 1'b0;
      #1;
   endtask

   initial begin
      int          st;
      logic [31:0] rd;
      logic        ws;
      int          ww0, fill0;

      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      for (int i = 0; i < 1024; i++) mem_model[i] = '0;
      mem_model[10'h004] = 128'h11111111_22222222_33333333_DEADBEEF;
      mem_model[10'h100] = 128'h99999999_88888888_77777777_5555AAAA;
      mem_model[10'h002] = 128'h44444444_44444444_44444444_44444444;

      repeat (2) tick();
      check_eq("rst_stall", bus.stall, 1'b0);
      check_eq("rst_mem_req", bus.mem_req, 1'b0);
      check_eq("rst_wr_block", bus.cache_write_block, 1'b0);
      check_eq("rst_miss_cnt", miss_count, 32'd0);
      check_eq("rst_wb_cnt", wb_count, 32'd0);
      reset = 1'b0;
      #1;

      // 1: cold load miss, clean refill
      access(32'h0000_0040, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t1_stalls", st, 5);
      check_eq("t1_rdata", rd, 32'hDEADBEEF);
      check_eq("t1_miss_cnt", miss_count, 32'd1);
      check_eq("t1_wb_cnt", wb_count, 32'd0);
      check_eq("t1_ntxn", txn_addr.size(), 1);
      check_eq("t1_txn_addr", txn_addr[0], 32'h40);
      check_eq("t1_txn_we", txn_we[0], 1'b0);
      check_eq("t1_mem_req", bus.mem_req, 1'b0);
      finish_access();

      // 2: hit on the refilled line
      access(32'h0000_0048, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t2_stalls", st, 0);
      check_eq("t2_rdata", rd, 32'h22222222);
      check_eq("t2_mem_req", bus.mem_req, 1'b0);
      check_eq("t2_wr_word", ws, 1'b0);
      finish_access();
      check_eq("t2_ntxn", txn_addr.size(), 1);

      // 3: sb then lb on a hit line
      ww0 = n_ww;
      access(32'h0000_0041, 1'b1, 1'b1, 32'h0000_00AB, st, rd, ws);
      check_eq("t3_sb_stalls", st, 0);
      check_eq("t3_sb_wr_word", ws, 1'b1);
      finish_access();
      check_eq("t3_ww_count", n_ww - ww0, 1);
      access(32'h0000_0041, 1'b0, 1'b1, 32'h0, st, rd, ws);
      check_eq("t3_lb_rdata", rd, 32'h0000_00AB);
      check_eq("t3_lb_wr_word", ws, 1'b0);
      finish_access();
      access(32'h0000_0040, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t3_lw_rdata", rd, 32'hDEADABEF);
      finish_access();

      // 4: store to index 0, then conflicting load forces writeback
      access(32'h0000_0044, 1'b1, 1'b0, 32'hCAFEF00D, st, rd, ws);
      check_eq("t4_sw_wr_word", ws, 1'b1);
      finish_access();
      access(32'h0000_1000, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t4_stalls", st, 8);
      check_eq("t4_rdata", rd, 32'h5555AAAA);
      check_eq("t4_ntxn", txn_addr.size(), 3);
      check_eq("t4_wb_addr", txn_addr[1], 32'h40);
      check_eq("t4_wb_we", txn_we[1], 1'b1);
      check_eq("t4_wb_data", txn_wdata[1], 128'h11111111_22222222_CAFEF00D_DEADABEF);
      check_eq("t4_rf_addr", txn_addr[2], 32'h1000);
      check_eq("t4_rf_we", txn_we[2], 1'b0);
      check_eq("t4_wb_cnt", wb_count, 32'd1);
      check_eq("t4_miss_cnt", miss_count, 32'd2);
      finish_access();

      // 5: reset while waiting in REFILL
      ww0   = n_ww;
      fill0 = n_fill;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0020;
      #1;
      check_eq("t5_miss_stall", bus.stall, 1'b1);
      tick();
      check_eq("t5_refill_req", bus.mem_req, 1'b1);
      check_eq("t5_refill_addr", bus.mem_addr, 32'h20);
      tick();
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      tick();
      check_eq("t5_mem_req", bus.mem_req, 1'b0);
      check_eq("t5_stall", bus.stall, 1'b0);
      check_eq("t5_miss_cnt", miss_count, 32'd0);
      check_eq("t5_wb_cnt", wb_count, 32'd0);
      reset = 1'b0;
      repeat (2) tick();
      check_eq("t5_mem_req_idle", bus.mem_req, 1'b0);
      check_eq("t5_no_fill", n_fill - fill0, 0);
      check_eq("t5_no_ww", n_ww - ww0, 0);
      access(32'h0000_1000, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t5_hit_stalls", st, 0);
      check_eq("t5_hit_rdata", rd, 32'h5555AAAA);
      finish_access();

      // 6: stray mem_ack in IDLE
      ww0   = n_ww;
      fill0 = n_fill;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      check_eq("t6_stall", bus.stall, 1'b0);
      check_eq("t6_mem_req", bus.mem_req, 1'b0);
      check_eq("t6_no_fill", n_fill - fill0, 0);
      check_eq("t6_no_ww", n_ww - ww0, 0);
      check_eq("t6_miss_cnt", miss_count, 32'd0);
      access(32'h0000_1004, 1'b0, 1'b0, 32'h0, st, rd, ws);
      check_eq("t6_hit_stalls", st, 0);
      check_eq("t6_hit_rdata", rd, 32'h77777777);
      finish_access();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

endmodule
